// File: rtl/spi_mem_responder.sv
// spi_mem_responder: SPI mode-0 target that decodes READ (0x03) / WRITE (0x02)
// frames and serves them from an internal byte array, all in the clk domain.
module spi_mem_responder #(
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned ADDR_BYTES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         busy,
  output logic                         wr_pulse,
  output logic [$clog2(MEM_DEPTH)-1:0] wr_addr,
  output logic [7:0]                   wr_data
);

  localparam int unsigned AW        = $clog2(MEM_DEPTH);
  localparam int unsigned ADDR_BITS = 8 * ADDR_BYTES;
  localparam int unsigned CNT_W     = $clog2(ADDR_BITS);
  localparam logic [7:0]  CMD_READ  = 8'h03;
  localparam logic [7:0]  CMD_WRITE = 8'h02;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_READ,
    S_WRITE,
    S_IGNORE
  } state_t;

  // Synchroniser chains; sclk keeps a third stage for edge detection.
  logic [2:0] sclk_sync_q, sclk_sync_d;
  logic [1:0] cs_sync_q, cs_sync_d;
  logic [1:0] mosi_sync_q, mosi_sync_d;

  logic sclk_rise_c;
  logic sclk_fall_c;
  logic cs_active_c;
  logic mosi_bit_c;

  // Decode state.
  state_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]     shift_q, shift_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [6:0]     tx_q, tx_d;
  logic           is_read_q, is_read_d;
  logic           primed_q, primed_d;
  logic           wait_high_q, wait_high_d;

  // Registered outputs.
  logic           miso_q, miso_d;
  logic           busy_q, busy_d;
  logic           wr_pulse_q, wr_pulse_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [7:0]     wr_data_q, wr_data_d;

  // Byte array (not reset) and its write strobe.
  logic [7:0]     mem_q [MEM_DEPTH];
  logic           mem_we_c;
  logic [7:0]     byte_in_c;
  logic [7:0]     rd_byte_c;

  // Next values for the pin synchronisers.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[0], cs_n};
    mosi_sync_d = {mosi_sync_q[0], mosi};
  end

  // Pin synchronisers; they only track the pins, so they carry no reset.
  always_ff @(posedge clk) begin
    sclk_sync_q <= sclk_sync_d;
    cs_sync_q   <= cs_sync_d;
    mosi_sync_q <= mosi_sync_d;
  end

  // Edge and level decode on the synchronised copies.
  always_comb begin
    sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
    sclk_fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
    cs_active_c = ~cs_sync_q[1];
    mosi_bit_c  = mosi_sync_q[1];
  end

  // Frame decoder: next state, shifters, pointer and output values.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    tx_d        = tx_q;
    is_read_d   = is_read_q;
    primed_d    = primed_q;
    wait_high_d = wait_high_q;
    miso_d      = miso_q;
    wr_pulse_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    mem_we_c    = 1'b0;
    byte_in_c   = {shift_q, mosi_bit_c};
    rd_byte_c   = 8'h00;

    if (!cs_active_c) begin
      // Deselected: drop any partial frame and re-arm after a reset.
      wait_high_d = 1'b0;
      state_d     = S_IDLE;
      cnt_d       = '0;
      shift_d     = '0;
      primed_d    = 1'b0;
      miso_d      = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A frame interrupted by reset stays ignored until cs_n cycles.
          if (!wait_high_q) begin
            state_d = S_CMD;
            cnt_d   = '0;
            shift_d = '0;
          end
        end

        S_CMD: begin
          if (sclk_rise_c) begin
            shift_d = byte_in_c[6:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d   = '0;
              shift_d = '0;
              if (byte_in_c == CMD_READ) begin
                state_d   = S_ADDR;
                is_read_d = 1'b1;
              end else if (byte_in_c == CMD_WRITE) begin
                state_d   = S_ADDR;
                is_read_d = 1'b0;
              end else begin
                state_d = S_IGNORE;
                miso_d  = 1'b0;
              end
            end
          end
        end

        S_ADDR: begin
          // Address bits shift straight into the pointer; high bits fall off.
          if (sclk_rise_c) begin
            ptr_d = AW'({ptr_q, mosi_bit_c});
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
              cnt_d = '0;
              if (is_read_q) begin
                // Preload so bit 7 is on miso before the first data rise.
                rd_byte_c = mem_q[ptr_d];
                miso_d    = rd_byte_c[7];
                tx_d      = rd_byte_c[6:0];
                primed_d  = 1'b0;
                state_d   = S_READ;
              end else begin
                state_d = S_WRITE;
              end
            end
          end
        end

        S_READ: begin
          // The fall right after the preload keeps bit 7; later falls shift.
          if (sclk_rise_c) begin
            primed_d = 1'b1;
          end else if (sclk_fall_c && primed_q) begin
            primed_d = 1'b0;
            if (cnt_q == CNT_W'(7)) begin
              cnt_d     = '0;
              ptr_d     = ptr_q + AW'(1);
              rd_byte_c = mem_q[ptr_d];
              miso_d    = rd_byte_c[7];
              tx_d      = rd_byte_c[6:0];
            end else begin
              cnt_d  = cnt_q + CNT_W'(1);
              miso_d = tx_q[6];
              tx_d   = {tx_q[5:0], 1'b0};
            end
          end
        end

        S_WRITE: begin
          if (sclk_rise_c) begin
            shift_d = byte_in_c[6:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(7)) begin
              cnt_d      = '0;
              shift_d    = '0;
              mem_we_c   = 1'b1;
              wr_pulse_d = 1'b1;
              wr_addr_d  = ptr_q;
              wr_data_d  = byte_in_c;
              ptr_d      = ptr_q + AW'(1);
            end
          end
        end

        S_IGNORE: begin
          miso_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          miso_d  = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == S_ADDR) || (state_d == S_READ) || (state_d == S_WRITE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      tx_q        <= '0;
      is_read_q   <= 1'b0;
      primed_q    <= 1'b0;
      wait_high_q <= 1'b1;
      miso_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_pulse_q  <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      tx_q        <= tx_d;
      is_read_q   <= is_read_d;
      primed_q    <= primed_d;
      wait_high_q <= wait_high_d;
      miso_q      <= miso_d;
      busy_q      <= busy_d;
      wr_pulse_q  <= wr_pulse_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[ptr_q] <= byte_in_c;
    end
  end

  assign miso     = miso_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_spi_mem_responder.sv
// Bench for spi_mem_responder: drives SPI mode-0 frames and scoreboards
// write strobes and read data against a byte-array model.
module tb_spi_mem_responder;

  localparam int unsigned HALF = 8;  // clk cycles per sclk half-period

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       busy;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_seen  = 0;

  logic [7:0]  model_mem [256];
  logic [15:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];
  logic [7:0]  rx_q [$];
  logic [15:0] exp_w;
  logic        bit_rx;
  logic [7:0]  last_rx;

  spi_mem_responder #(
    .MEM_DEPTH (256),
    .ADDR_BYTES(3)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sclk    (sclk),
    .cs_n    (cs_n),
    .mosi    (mosi),
    .miso    (miso),
    .busy    (busy),
    .wr_pulse(wr_pulse),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always #5 clk = ~clk;

  // Write-strobe scoreboard: every pulse must match the next expected write.
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      wr_seen++;
      n_checks++;
      if (exp_wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr, wr_data);
      end else begin
        exp_w = exp_wr_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w)
          begin
            n_fail++;
            $display("FAIL wr_commit: got addr=%h data=%h, required addr=%h data=%h",
                     wr_addr, wr_data, exp_w[15:8], exp_w[7:0]);
          end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b);
    mosi = b;
    wait_clk(HALF);
    sclk   = 1'b1;
    bit_rx = miso;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(b[i]);
      last_rx[i] = bit_rx;
    end
  endtask

  task automatic cs_begin();
    cs_n = 1'b0;
    wait_clk(6);
  endtask

  task automatic cs_end();
    wait_clk(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(8);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
    xfer_byte(cmd);
    xfer_byte(addr[23:16]);
    xfer_byte(addr[15:8]);
    xfer_byte(addr[7:0]);
  endtask

  // Drives a write frame and records the expected commits and new contents.
  task automatic write_frame(input logic [23:0] addr, input logic [7:0] d0,
                             input logic [7:0] d1, input int n);
    logic [7:0] a;
    logic [7:0] d;
    cs_begin();
    send_header(8'h02, addr);
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? d0 : d1;
      a = addr[7:0] + 8'(i);
      model_mem[a] = d;
      exp_wr_q.push_back({a, d});
      xfer_byte(d);
    end
    cs_end();
  endtask

  // Drives a read frame and collects n returned bytes into rx_q.
  task automatic read_frame(input logic [23:0] addr, input int n);
    rx_q.delete();
    cs_begin();
    send_header(8'h03, addr);
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'h00);
      rx_q.push_back(last_rx);
    end
    cs_end();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    wait_clk(5);
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b, required 0", miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_checks++; if (wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pulse: got %b, required 0", wr_pulse); end
    n_checks++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr: got %h, required 00", wr_addr); end
    n_checks++; if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h, required 00", wr_data); end
    rst = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_write();
    logic [7:0] hdr [4];
    logic [7:0] dat [2];
    int w0;
    hdr[0] = 8'h02; hdr[1] = 8'h00; hdr[2] = 8'h00; hdr[3] = 8'h10;
    dat[0] = 8'hA5; dat[1] = 8'h3C;
    w0 = wr_seen;
    cs_begin();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_pre_cmd: got %b, required 0", busy); end
    for (int i = 0; i < 4; i++) begin
      xfer_byte(hdr[i]);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_hdr%0d: got %b, required 1", i, busy); end
    end
    for (int i = 0; i < 2; i++) begin
      model_mem[8'h10 + 8'(i)] = dat[i];
      exp_wr_q.push_back({8'h10 + 8'(i), dat[i]});
      xfer_byte(dat[i]);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL write_busy_data%0d: got %b, required 1", i, busy); end
    end
    cs_end();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL write_busy_post: got %b, required 0", busy); end
    n_checks++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL write_pending: got %0d outstanding, required 0", exp_wr_q.size()); end
    n_checks++; if (wr_seen - w0 != 2) begin n_fail++; $display("FAIL write_pulse_count: got %0d, required 2", wr_seen - w0); end
  endtask

  task automatic test_read();
    logic [7:0] e;
    exp_rd_q.push_back(model_mem[8'h10]);
    exp_rd_q.push_back(model_mem[8'h11]);
    read_frame(24'h000010, 2);
    for (int i = 0; i < 2; i++) begin
      e = exp_rd_q.pop_front();
      n_checks++;
      if (rx_q[i] !== e) begin n_fail++; $display("FAIL read_byte%0d: got %h, required %h", i, rx_q[i], e); end
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e;
    write_frame(24'h0000FF, 8'hDE, 8'hAD, 2);
    n_checks++; if (exp_wr_q.size() != 0) begin n_fail++; $display("FAIL wrap_write_pending: got %0d outstanding, required 0", exp_wr_q.size()); end
    exp_rd_q.push_back(model_mem[8'hFF]);
    exp_rd_q.push_back(model_mem[8'h00]);
    read_frame(24'h0000FF, 2);
    for (int i = 0; i < 2; i++) begin
      e = exp_rd_q.pop_front();
      n_checks++;
      if (rx_q[i] !== e) begin n_fail++; $display("FAIL wrap_read%0d: got %h, required %h", i, rx_q[i], e); end
    end
    exp_rd_q.push_back(model_mem[8'hFF]);
    read_frame(24'h1234FF, 1);
    e = exp_rd_q.pop_front();
    n_checks++; if (rx_q[0] !== e) begin n_fail++; $display("FAIL wrap_alias: got %h, required %h", rx_q[0], e); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] e;
    int w0;
    w0 = wr_seen;
    cs_begin();
    xfer_byte(8'h9F);
    for (int i = 0; i < 4; i++) begin
      xfer_byte(8'($urandom));
      n_checks++;
      if (last_rx !== 8'h00) begin n_fail++; $display("FAIL bad_miso%0d: got %h, required 00", i, last_rx); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_busy%0d: got %b, required 0", i, busy); end
    end
    cs_end();
    n_checks++; if (wr_seen != w0) begin n_fail++; $display("FAIL bad_wr_pulse: got %0d pulses, required 0", wr_seen - w0); end
    exp_rd_q.push_back(model_mem[8'h10]);
    read_frame(24'h000010, 1);
    e = exp_rd_q.pop_front();
    n_checks++; if (rx_q[0] !== e) begin n_fail++; $display("FAIL bad_next_frame: got %h, required %h", rx_q[0], e); end
  endtask

  task automatic test_abort();
    logic [7:0] e;
    int w0;
    write_frame(24'h000020, 8'h5A, 8'h00, 1);
    w0 = wr_seen;
    cs_begin();
    send_header(8'h02, 24'h000020);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_mid: got %b, required 1", busy); end
    cs_n = 1'b1;
    mosi = 1'b0;
    wait_clk(3);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle_3clk: got busy=%b, required 0", busy); end
    wait_clk(HALF);
    n_checks++; if (wr_seen != w0) begin n_fail++; $display("FAIL abort_wr_pulse: got %0d pulses, required 0", wr_seen - w0); end
    exp_rd_q.push_back(model_mem[8'h20]);
    read_frame(24'h000020, 1);
    e = exp_rd_q.pop_front();
    n_checks++; if (rx_q[0] !== e) begin n_fail++; $display("FAIL abort_mem: got %h, required %h", rx_q[0], e); end
  endtask

  task automatic test_rst_mid_read();
    logic [7:0] e;
    cs_begin();
    send_header(8'h03, 24'h000010);
    e = model_mem[8'h10];
    n_checks++; if (miso !== e[7]) begin n_fail++; $display("FAIL rstmid_preload: got %b, required %b", miso, e[7]); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_pre: got %b, required 1", busy); end
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    n_checks++; if (miso !== 1'b0) begin n_fail++; $display("FAIL rstmid_miso: got %b, required 0", miso); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    for (int i = 0; i < 2; i++) begin
      xfer_byte(8'h03);
      n_checks++;
      if (last_rx !== 8'h00) begin n_fail++; $display("FAIL rstmid_tail_miso%0d: got %h, required 00", i, last_rx); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_tail_busy%0d: got %b, required 0", i, busy); end
    end
    cs_end();
    exp_rd_q.push_back(model_mem[8'h11]);
    read_frame(24'h000011, 1);
    e = exp_rd_q.pop_front();
    n_checks++; if (rx_q[0] !== e) begin n_fail++; $display("FAIL rstmid_next_frame: got %h, required %h", rx_q[0], e); end
  endtask

  initial begin
    rst  = 1'b1;
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_bad_cmd();
    test_abort();
    test_rst_mid_read();
    wait_clk(10);
    n_checks++;
    if (exp_wr_q.size() != 0) begin
      n_fail++;
      $display("FAIL final_wr_pending: got %0d outstanding, required 0", exp_wr_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_mem_responder.md
# spi_mem_responder

SPI-mode-0 serial memory responder: the target-side counterpart of the memory bus's SPI initiator path. It decodes the 8-bit READ/WRITE command, 24-bit address and data stream that the bus sends on sclk/mosi under an active-low chip select, and serves reads from and writes to an internal byte array. It is used as an on-chip stand-in for the external SPI RAM on cs2, and as the bench model for memory-bus regression.

## Interface
Parameters:
- MEM_DEPTH, 256: bytes in internal array; power of two; address uses low log2(MEM_DEPTH) bits.
- ADDR_BYTES, 3: address bytes following the command.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI clock from initiator; asynchronous to clk; idles low.
- cs_n  in  1  chip select, active low; asynchronous to clk.
- mosi  in  1  serial data in, MSB first.
- miso  out  1  serial data out, MSB first.
- busy  out  1  high while a recognised READ/WRITE transaction is in progress.
- wr_pulse  out  1  one-clk strobe per completed write byte.
- wr_addr  out  log2(MEM_DEPTH)  array address of the last written byte.
- wr_data  out  8  value of the last written byte.

## Operation
- sclk, cs_n and mosi each pass through a 2-flop synchroniser; rising/falling sclk edges are detected on the synchronised copy. All decoding is in the clk domain.
- Mode 0: mosi is sampled on the detected sclk rise; miso changes on the detected sclk fall, except when the first data bit is preloaded (below).
- States: IDLE, CMD, ADDR, READ, WRITE, IGNORE.
- IDLE: synchronised cs_n low -> CMD; bit counter = 0.
- CMD: shift 8 bits. At the 8th bit: 0x03 -> ADDR (read), 0x02 -> ADDR (write), any other value -> IGNORE.
- ADDR: shift 8×ADDR_BYTES bits; the low log2(MEM_DEPTH) bits become the pointer, and upper bits are discarded. On the last address bit, a read loads mem[pointer] into the tx shifter, drives its bit 7 on miso, then -> READ. A write goes -> WRITE.
- READ: on each fall, shift the next bit out. After 8 bits, pointer++ and load mem[pointer] so that its MSB is on miso at that fall; the transaction continues indefinitely.
- WRITE: shift 8 bits in. On the 8th rise, write mem[pointer] = byte, pulse wr_pulse for one clk with wr_addr/wr_data, then pointer++.
- IGNORE: consume clocks and keep miso = 0 until cs_n rises.
- Pointer wrap: MEM_DEPTH-1 increments to 0, for both read and write.
- cs_n rising in any state -> IDLE within 3 clk. A partial write byte is discarded (no write, no wr_pulse); the partial command/address is dropped.
- cs_n high: miso = 0, busy = 0, and sclk edges are ignored.
- busy = 1 in ADDR (after a valid command), READ and WRITE; 0 otherwise.
- Memory contents are not reset. rst does not clear the array.

## Timing
- Requirement: clk ≥ 8× sclk frequency (each sclk half-period ≥ 4 clk); cs_n setup to first sclk rise ≥ 4 clk.
- Edge-to-action latency: 3 clk from a pin edge (2 synchroniser + 1 register).
- miso is valid ≤ 4 clk after the sclk fall that triggers it, and for the first read byte ≤ 4 clk after the last address rise; both fit within the half-period.
- Write commit: wr_pulse is asserted 3 clk after the 8th data-bit rise on the pin. A read of the same address in a later transaction sees the new value.
- Reset values: state IDLE, miso 0, busy 0, wr_pulse 0, wr_addr 0, wr_data 0, pointer 0, shifters 0.
- rst mid-transaction -> IDLE next clk. Any remaining bits of that cs_n frame are ignored until cs_n goes high and then low again.

## Test plan
- Write 0x02,0x00,0x00,0x10,0xA5,0x3C -> wr_pulse twice, with (0x10,0xA5) then (0x11,0x3C); busy is high through the frame.
- Read 0x03,0x00,0x00,0x10 followed by 16 sclks -> miso yields 0xA5, 0x3C MSB-first, sampled on sclk rises.
- Wrap: write 0xDE at 0xFF and 0xAD at 0x00 in one frame starting at addr 0x0000FF. A read from 0x0000FF returns 0xDE, 0xAD. Address 0x1234FF aliases to 0xFF.
- Bad command 0x9F followed by 32 sclks -> miso stays 0, busy 0, no wr_pulse. The next valid frame works normally.
- Abort: write frame with cs_n raised after 5 data bits -> no wr_pulse, array unchanged, state IDLE within 3 clk.
- rst asserted mid-read -> miso 0 and busy 0 next clk. The frame following the next cs_n fall decodes correctly.
